pool1_relu_rx: RTL and testbench

//  Receiving end of the conv1 output stream. Takes the raster-ordered 3-channel
//  24x24 feature map (one pixel per valid_in pulse) and applies 2x2/stride-2 max

---
 rtl/pool1_relu_rx.sv | 161 ++++++++++++++++
 tb/tb_pool1_relu_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_relu_rx.sv
// 2x2/stride-2 max pooling + ReLU on a raster-ordered 3-channel conv1 stream.
// One lane per channel holds the even-column sample and a row of partial maxima.

module pool1_relu_lane #(
   parameter int DATA_W = 12,
   parameter int HALF   = 12,
   parameter int PW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_i,
   input  logic              odd_x_i,
   input  logic              odd_y_i,
   input  logic [PW-1:0]     col_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] res_o
);
   logic signed [DATA_W-1:0] sin;
   logic signed [DATA_W-1:0] hold_q;
   logic signed [DATA_W-1:0] part_q [HALF];
   logic signed [DATA_W-1:0] max2, max3;

   assign sin = $signed(din_i);

   always_comb begin
      max2  = (hold_q > sin) ? hold_q : sin;
      max3  = (max2 > part_q[col_i]) ? max2 : part_q[col_i];
      res_o = max3[DATA_W-1] ? '0 : max3;
   end

   // Buffer is deliberately unreset: every entry is written on the even row
   // before the odd row of the same window reads it.
   always_ff @(posedge clk) begin
      if (!rst && beat_i) begin
         if (!odd_x_i)
            hold_q <= sin;
         else if (!odd_y_i)
            part_q[col_i] <= max2;
      end
   end
endmodule

module pool1_relu_rx #(
   parameter int IN_WIDTH  = 24,
   parameter int IN_HEIGHT = 24,
   parameter int DATA_W    = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] conv_in_1,
   input  logic [DATA_W-1:0] conv_in_2,
   input  logic [DATA_W-1:0] conv_in_3,
   input  logic              valid_in,
   output logic [DATA_W-1:0] pool_out_1,
   output logic [DATA_W-1:0] pool_out_2,
   output logic [DATA_W-1:0] pool_out_3,
   output logic              valid_out,
   output logic              busy,
   output logic              frame_done
);
   localparam int NCH  = 3;
   localparam int HALF = IN_WIDTH / 2;
   localparam int XW   = $clog2(IN_WIDTH);
   localparam int YW   = $clog2(IN_HEIGHT);
   localparam int PW   = XW - 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                        state_q, state_d;
   logic [XW-1:0]                 x_q, x_d;
   logic [YW-1:0]                 y_q, y_d;
   logic [NCH-1:0][DATA_W-1:0]    pool_q, pool_d;
   logic                          valid_q, valid_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic [NCH-1:0][DATA_W-1:0]    din;
   logic [DATA_W-1:0]             res [NCH];
   logic                          x_wrap, y_last, last_beat, fire;

   assign din       = {conv_in_3, conv_in_2, conv_in_1};
   assign x_wrap    = (x_q == XW'(IN_WIDTH - 1));
   assign y_last    = (y_q == YW'(IN_HEIGHT - 1));
   assign last_beat = x_wrap && y_last;
   assign fire      = valid_in && x_q[0] && y_q[0];

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      pool1_relu_lane #(
         .DATA_W (DATA_W),
         .HALF   (HALF),
         .PW     (PW)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .beat_i  (valid_in),
         .odd_x_i (x_q[0]),
         .odd_y_i (y_q[0]),
         .col_i   (x_q[XW-1:1]),
         .din_i   (din[g]),
         .res_o   (res[g])
      );
   end

   // State register (also carries counters and registered outputs)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         pool_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pool_q  <= pool_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state: x/y are zero whenever the FSM sits in IDLE, so the first
   // accepted beat is always pixel (0,0).
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         IDLE:    if (valid_in) state_d = last_beat ? IDLE : RUN;
         RUN:     if (valid_in && last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (valid_in) begin
         if (x_wrap) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Output logic
   always_comb begin
      pool_d  = pool_q;
      valid_d = fire;
      done_d  = valid_in && last_beat;
      busy_d  = (state_d == RUN);
      if (fire)
         for (int i = 0; i < NCH; i++) pool_d[i] = res[i];
   end

   assign pool_out_1 = pool_q[0];
   assign pool_out_2 = pool_q[1];
   assign pool_out_3 = pool_q[2];
   assign valid_out  = valid_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_pool1_relu_rx.sv
// Directed bench for pool1_relu_rx: pixel patterns are generated here and the
// expected pooled outputs come from a whole-window reference, not a stream model.

module tb_pool1_relu_rx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] conv_in_1 = '0, conv_in_2 = '0, conv_in_3 = '0;
   logic        valid_in = 1'b0;
   logic [11:0] pool_out_1, pool_out_2, pool_out_3;
   logic        valid_out, busy, frame_done;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int stray  = 0;
   int acc11  = 0;

   typedef struct {
      logic [11:0] v0, v1, v2;
      logic        fd;
      int          cyc;
   } pulse_t;
   pulse_t q[$];
   pulse_t qa[$];

   pool1_relu_rx dut (
      .clk(clk), .rst(rst),
      .conv_in_1(conv_in_1), .conv_in_2(conv_in_2), .conv_in_3(conv_in_3),
      .valid_in(valid_in),
      .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
      .valid_out(valid_out), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      pulse_t p;
      if (valid_out) begin
         p.v0 = pool_out_1; p.v1 = pool_out_2; p.v2 = pool_out_3;
         p.fd = frame_done; p.cyc = cyc;
         q.push_back(p);
      end
      if (frame_done && !valid_out) stray++;
   end

   // kind 0: ramp, 1: constant -100, 2: hash pattern, 3: single window on ch0
   function automatic int pix(int kind, int ch, int x, int y, int seed);
      case (kind)
         0: return (ch == 0) ? x + 24*y : (ch == 1) ? -(x + 24*y) : (x - y) * 50;
         1: return -100;
         2: return ((x*37 + y*101 + ch*53 + seed*17 + x*y*7) % 4001) - 2000;
         default: begin
            if (ch != 0 || x > 1 || y > 1) return 0;
            case ({y[0], x[0]})
               2'b00: return 5;
               2'b01: return -3;
               2'b10: return 7;
               default: return 2;
            endcase
         end
      endcase
   endfunction

   function automatic logic [11:0] expv(int kind, int ch, int r, int c, int seed);
      int m;
      m = pix(kind, ch, 2*c, 2*r, seed);
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++)
            if (pix(kind, ch, 2*c+dx, 2*r+dy, seed) > m) m = pix(kind, ch, 2*c+dx, 2*r+dy, seed);
      return (m < 0) ? 12'd0 : 12'(m);
   endfunction

   // Leaves the last beat driven (not yet clocked) so frames can abut.
   task automatic send_frame(input int kind, input int seed, input int gap,
                             input int nbeats, input bit chk_busy);
      int n = 0;
      for (int y = 0; y < 24; y++)
         for (int x = 0; x < 24; x++) begin
            if (n < nbeats) begin
               @(negedge clk);
               if (chk_busy && n > 0) begin
                  n_chk++;
                  if (busy !== 1'b1) begin
                     n_fail++;
                     $display("FAIL busy_mid beat %0d got %b want 1", n, busy);
                  end
               end
               valid_in  = 1'b1;
               conv_in_1 = 12'(pix(kind, 0, x, y, seed));
               conv_in_2 = 12'(pix(kind, 1, x, y, seed));
               conv_in_3 = 12'(pix(kind, 2, x, y, seed));
               if (x == 1 && y == 1) acc11 = cyc + 1;
               n++;
               if (n < nbeats)
                  repeat (gap) begin @(negedge clk); valid_in = 1'b0; end
            end
         end
   endtask

   task automatic go_idle();
      @(negedge clk);
      valid_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if ({pool_out_1, pool_out_2, pool_out_3, valid_out, busy, frame_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got %h/%h/%h v%b b%b d%b want all 0",
                  pool_out_1, pool_out_2, pool_out_3, valid_out, busy, frame_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_window();
      q.delete();
      send_frame(3, 0, 0, 576, 1'b0);
      go_idle();
      n_chk++;
      if (q.size() != 144) begin
         n_fail++; $display("FAIL window_count got %0d want 144", q.size());
      end
      if (q.size() > 0) begin
         n_chk++;
         if (q[0].v0 !== 12'd7 || q[0].v1 !== 12'd0 || q[0].v2 !== 12'd0) begin
            n_fail++;
            $display("FAIL window_first got %0d/%0d/%0d want 7/0/0", q[0].v0, q[0].v1, q[0].v2);
         end
         n_chk++;
         if (q[0].cyc != acc11) begin
            n_fail++; $display("FAIL window_latency got cycle %0d want %0d", q[0].cyc, acc11);
         end
      end
   endtask

   task automatic test_negative();
      int bad = 0;
      q.delete();
      send_frame(1, 0, 0, 576, 1'b0);
      go_idle();
      foreach (q[k]) if ({q[k].v0, q[k].v1, q[k].v2} !== '0) bad++;
      n_chk++;
      if (q.size() != 144 || bad != 0) begin
         n_fail++; $display("FAIL negative_relu got %0d pulses %0d nonzero want 144 0", q.size(), bad);
      end
   endtask

   task automatic test_ramp();
      int bad = 0, fdbad = 0;
      q.delete();
      send_frame(0, 0, 0, 576, 1'b1);
      @(negedge clk);
      valid_in = 1'b0;
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL busy_after_last got %b want 0", busy);
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (q.size() != 144) begin
         n_fail++; $display("FAIL ramp_count got %0d want 144", q.size());
      end
      foreach (q[k]) begin
         if (q[k].v0 !== 12'((2*(k/12)+1)*24 + 2*(k%12) + 1)) bad++;
         if (q[k].v1 !== expv(0, 1, k/12, k%12, 0) || q[k].v2 !== expv(0, 2, k/12, k%12, 0)) bad++;
         if (q[k].fd !== (k == 143)) fdbad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++; $display("FAIL ramp_values got %0d bad pulses want 0", bad);
      end
      n_chk++;
      if (fdbad != 0) begin
         n_fail++; $display("FAIL ramp_frame_done got %0d misplaced want 0", fdbad);
      end
   endtask

   task automatic test_spacing();
      int bad = 0;
      q.delete();
      send_frame(2, 5, 0, 576, 1'b0);
      go_idle();
      qa = q;
      q.delete();
      send_frame(2, 5, 6, 576, 1'b0);
      go_idle();
      n_chk++;
      if (qa.size() != 144 || q.size() != 144) begin
         n_fail++; $display("FAIL spacing_count got %0d/%0d want 144/144", qa.size(), q.size());
      end
      for (int k = 0; k < 144 && k < q.size() && k < qa.size(); k++) begin
         if (qa[k].v0 !== expv(2, 0, k/12, k%12, 5) || qa[k].v1 !== expv(2, 1, k/12, k%12, 5) ||
             qa[k].v2 !== expv(2, 2, k/12, k%12, 5)) bad++;
         if (q[k].v0 !== qa[k].v0 || q[k].v1 !== qa[k].v1 || q[k].v2 !== qa[k].v2) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++; $display("FAIL spacing_values got %0d bad want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      q.delete();
      send_frame(2, 7, 0, 576, 1'b0);
      send_frame(2, 8, 0, 576, 1'b0);
      go_idle();
      n_chk++;
      if (q.size() != 288) begin
         n_fail++; $display("FAIL b2b_count got %0d want 288", q.size());
      end
      for (int k = 0; k < q.size() && k < 288; k++) begin
         int s = (k < 144) ? 7 : 8;
         int j = k % 144;
         if (q[k].v0 !== expv(2, 0, j/12, j%12, s) || q[k].v1 !== expv(2, 1, j/12, j%12, s) ||
             q[k].v2 !== expv(2, 2, j/12, j%12, s)) bad++;
         if (q[k].fd !== (j == 143)) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++; $display("FAIL b2b_values got %0d bad want 0", bad);
      end
   endtask

   task automatic test_abort();
      int bad = 0;
      send_frame(2, 9, 0, 300, 1'b0);
      @(negedge clk);
      rst = 1'b1;              // beat still driven: reset must win
      conv_in_1 = 12'h7ff; conv_in_2 = 12'h7ff; conv_in_3 = 12'h7ff;
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      q.delete();
      n_chk++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_state got v%b b%b want 0 0", valid_out, busy);
      end
      send_frame(2, 10, 1, 576, 1'b0);
      go_idle();
      n_chk++;
      if (q.size() != 144) begin
         n_fail++; $display("FAIL abort_count got %0d want 144", q.size());
      end
      for (int k = 0; k < q.size() && k < 144; k++)
         if (q[k].v0 !== expv(2, 0, k/12, k%12, 10) || q[k].v1 !== expv(2, 1, k/12, k%12, 10) ||
             q[k].v2 !== expv(2, 2, k/12, k%12, 10)) bad++;
      n_chk++;
      if (bad != 0) begin
         n_fail++; $display("FAIL abort_values got %0d bad want 0", bad);
      end
      n_chk++;
      if (stray != 0) begin
         n_fail++; $display("FAIL frame_done_alone got %0d want 0", stray);
      end
   endtask

   initial begin
      test_reset();
      test_window();
      test_negative();
      test_ramp();
      test_spacing();
      test_back_to_back();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
